// File: rtl/node_sequencer.sv
// Upstream control/buffer stage for one ANN node: loads N_INPUTS words over valid/ready,
// then sequences the node accumulator through one clear cycle, N_INPUTS accumulate cycles and a done pulse.
module node_sequencer #(
   parameter int unsigned N_INPUTS = 64,
   parameter int unsigned BITS     = 16,
   parameter int unsigned CNT_W    = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [BITS-1:0]            in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [N_INPUTS*BITS-1:0]   data_out,
   output logic                       reset_acc,
   output logic                       start,
   output logic [CNT_W-1:0]           cnt_val,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned DATA_W = N_INPUTS * BITS;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              in_ready_q, in_ready_d;
   logic              reset_acc_q, reset_acc_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept;

   // Next state, buffer writes and counters; outputs are decoded from the next state so they register cleanly.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      accept  = in_valid & in_ready_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d[BITS-1:0] = in_data;
               idx_d            = CNT_W'(1);
               state_d          = (N_INPUTS == 1) ? S_CLEAR : S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               data_d[32'(idx_q)*BITS +: BITS] = in_data;
               idx_d = idx_q + CNT_W'(1);
               if (idx_q == LAST) begin
                  state_d = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_ACCUM;
         end
         S_ACCUM: begin
            // Hold the last term index into DONE rather than wrapping.
            if (cnt_q == LAST) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
      reset_acc_d = (state_d == S_CLEAR);
      start_d     = (state_d != S_ACCUM);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         in_ready_q  <= 1'b0;
         reset_acc_q <= 1'b1;
         start_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         in_ready_q  <= in_ready_d;
         reset_acc_q <= reset_acc_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign data_out  = data_q;
   assign reset_acc = reset_acc_q;
   assign start     = start_q;
   assign cnt_val   = cnt_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: doc/node_sequencer.md
Name: node_sequencer

Overview:
- Upstream control/buffer stage for one ANN node.
- Accepts a serial stream of 16-bit data words over a valid/ready handshake and stores N_INPUTS of them in a register buffer.
- After the buffer is full, it drives the node's accumulator controls (reset_acc, start, cnt_val) through one clear cycle and N_INPUTS accumulate cycles.
- It then pulses done, so downstream logic can sample node_out.

Parameters:
- N_INPUTS, 64: number of data words per node evaluation.
- BITS, 16: data word width.
- CNT_W, 7: width of cnt_val. Must satisfy 2^CNT_W > N_INPUTS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_data  input  BITS  next data word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  sequencer accepts a word this cycle.
- data_out  output  BITS x N_INPUTS  buffered words, indexed 0..N_INPUTS-1; drives node data_in.
- reset_acc  output  1  1 = clear node accumulator.
- start  output  1  1 = node accumulator holds; 0 = node accumulates term cnt_val.
- cnt_val  output  CNT_W  term index presented to the node.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; node_out is valid in this cycle.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-LOAD or mid-ACCUM:
  - state=IDLE, load index=0, all data_out words=0.
  - reset_acc=1, start=1, cnt_val=0, in_ready=0, busy=0, done=0.
- All outputs are registered. No combinational path from any input to any output.
- Handshake: a word is accepted at an edge only when in_valid=1 and in_ready=1. in_data is ignored otherwise.
- State IDLE:
  - Outputs: in_ready=1, reset_acc=0, start=1.
  - Accepting a word writes data_out[0], sets index=1 and moves to LOAD.
- State LOAD:
  - Outputs: in_ready=1, start=1.
  - Each accepted word writes data_out[index] and increments index.
  - in_valid=0 stalls: index and buffer hold.
  - The edge that accepts word N_INPUTS-1 moves to CLEAR and drops in_ready for the next cycle. The word-N_INPUTS transfer therefore can never occur.
- State CLEAR, exactly 1 cycle:
  - Outputs: reset_acc=1, start=1, cnt_val=0, in_ready=0.
  - Next state: ACCUM.
- State ACCUM, exactly N_INPUTS cycles:
  - Outputs: reset_acc=0, start=0, cnt_val=0,1,...,N_INPUTS-1 (one value per cycle), in_ready=0.
  - After the cycle with cnt_val=N_INPUTS-1, go to DONE.
  - cnt_val never reaches N_INPUTS (no wrap).
- State DONE, exactly 1 cycle:
  - Outputs: done=1, start=1, reset_acc=0, cnt_val held at N_INPUTS-1, in_ready=0.
  - Next state: IDLE.
- Buffer contents persist through CLEAR, ACCUM, DONE and IDLE until overwritten by the next load.
- Latency: the first edge on which the last word is accepted is edge L. CLEAR is the cycle after L, ACCUM spans N_INPUTS cycles, and done=1 in cycle L+N_INPUTS+2.
- Back-to-back: in_valid held high in the DONE cycle is not accepted because in_ready=0. The first accept is in the following IDLE cycle.
- Simultaneous rst=1 and in_valid=1: reset wins and no word is stored.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_data=16'hFFFF -> IDLE, in_ready=0 during reset, all data_out=0, done=0, busy=0; in_ready=1 on the first cycle after rst falls.
- Full load: stream 64 words 16'h0001..16'h0040 with in_valid held high ->
  - data_out[k]=k+1;
  - in_ready=0 from the cycle after the 64th accept;
  - one reset_acc=1 cycle;
  - 64 cycles of start=0 with cnt_val 0..63;
  - done=1 exactly 66 cycles after the last accept.
- Stall: deassert in_valid for 5 cycles after word 10 -> index holds, data_out[10..63] unchanged until resumed; final buffer matches the 64-word sequence; done arrives 5 cycles later than in the full-load test.
- Reset mid-ACCUM: assert rst when cnt_val=30 -> next cycle IDLE, buffer all 0, start=1, no done pulse.
- Back-to-back: keep in_valid=1 through DONE -> no accept in the DONE cycle; the first word of the second frame lands in data_out[0] in the following IDLE cycle.
- Boundary: after the 64th accept, drive a 65th word 16'hDEAD with in_valid=1 -> not accepted, data_out[0] unchanged, cnt_val never exceeds 63.
